// File: rtl/q_learning_accel_if.sv
// Handshake/bus bundle for the Q-learning update engine.
// The master side drives the update request; the slave side returns the Q-value reads.
interface q_learning_accel_if;
   logic               decoder_en;
   logic        [4:0]  current_state;
   logic        [3:0]  step;
   logic        [4:0]  next_state;
   logic        [1:0]  act;
   logic signed [31:0] Q_max;
   logic signed [31:0] Qnext_0;
   logic signed [31:0] Qnext_1;
   logic signed [31:0] Qnext_2;
   logic signed [31:0] Qnext_3;

   modport master (
      output decoder_en, current_state, step, next_state, act,
      input  Q_max, Qnext_0, Qnext_1, Qnext_2, Qnext_3
   );

   modport slave (
      input  decoder_en, current_state, step, next_state, act,
      output Q_max, Qnext_0, Qnext_1, Qnext_2, Qnext_3
   );
endinterface

// File: rtl/q_learning_accel.sv
// Q-table (4 action banks x 32 states) with a one-edge TD update, alpha = gamma = 1/2.
// Define QLA_STEP_PENALTY_EN to make the ordinary reward -1 instead of 0.
module q_learning_accel (
   input logic               clk,
   input logic               rst,
   q_learning_accel_if.slave bus
);

`ifdef QLA_STEP_PENALTY_EN
   localparam logic signed [31:0] ORD_REWARD = -32'sd1;
`else
   localparam logic signed [31:0] ORD_REWARD = 32'sd0;
`endif

   logic signed [31:0] r_q [4][32];
   logic signed [31:0] w_qn [4];
   logic signed [31:0] w_qmax;
   logic signed [31:0] w_qsa;
   logic signed [31:0] w_reward;
   logic signed [31:0] w_half_max;
   logic signed [31:0] w_diff;
   logic signed [31:0] w_qnew;
   logic               w_trap;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_qn[k] = r_q[k][bus.next_state];
      end
   end

   // Strict compare keeps the lowest-index bank on ties.
   always_comb begin
      w_qmax = w_qn[0];
      for (int k = 1; k < 4; k++) begin
         if (w_qn[k] > w_qmax) begin
            w_qmax = w_qn[k];
         end
      end
   end

   assign w_qsa = r_q[bus.act][bus.current_state];

   assign w_trap = (bus.next_state == 5'd8)
                || (bus.next_state == 5'd12)
                || (bus.next_state == 5'd17)
                || (bus.next_state == 5'd19);

   always_comb begin
      w_reward = ORD_REWARD;
      if (bus.next_state == 5'd25) begin
         w_reward = 32'sd100;
      end else if (w_trap || (bus.step == 4'd15)) begin
         w_reward = -32'sd50;
      end
   end

   assign w_half_max = w_qmax >>> 1;
   assign w_diff     = w_reward + w_half_max - w_qsa;
   assign w_qnew     = w_qsa + (w_diff >>> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 32; j++) begin
               r_q[i][j] <= '0;
            end
         end
      end else if (bus.decoder_en) begin
         r_q[bus.act][bus.current_state] <= w_qnew;
      end
   end

   assign bus.Q_max   = w_qmax;
   assign bus.Qnext_0 = w_qn[0];
   assign bus.Qnext_1 = w_qn[1];
   assign bus.Qnext_2 = w_qn[2];
   assign bus.Qnext_3 = w_qn[3];

endmodule

// File: tb/tb_q_learning_accel.sv
// Directed self-checking bench for q_learning_accel (default build, no step penalty).
module tb_q_learning_accel;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   q_learning_accel_if bus ();

   q_learning_accel dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic en, input logic [1:0] a,
                        input logic [4:0] cs, input logic [4:0] ns,
                        input logic [3:0] st);
      bus.decoder_en    = en;
      bus.act           = a;
      bus.current_state = cs;
      bus.next_state    = ns;
      bus.step          = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [4:0] cs,
                           input logic [4:0] ns, input logic [3:0] st);
      drive(1'b1, a, cs, ns, st);
      tick();
      bus.decoder_en = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b0, 2'd0, 5'd1, 5'd6, 4'd1);
      rst = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      n_chk++; if (bus.Q_max !== 32'sd0) begin n_err++; $display("FAIL reset_qmax got=%0d exp=0", bus.Q_max); end
      n_chk++; if (bus.Qnext_0 !== 32'sd0) begin n_err++; $display("FAIL reset_qn0 got=%0d exp=0", bus.Qnext_0); end
      n_chk++; if (bus.Qnext_1 !== 32'sd0) begin n_err++; $display("FAIL reset_qn1 got=%0d exp=0", bus.Qnext_1); end
      n_chk++; if (bus.Qnext_2 !== 32'sd0) begin n_err++; $display("FAIL reset_qn2 got=%0d exp=0", bus.Qnext_2); end
      n_chk++; if (bus.Qnext_3 !== 32'sd0) begin n_err++; $display("FAIL reset_qn3 got=%0d exp=0", bus.Qnext_3); end
      tick();
      bus.next_state = 5'd1;
      #1;
      n_chk++; if (bus.Qnext_0 !== 32'sd0) begin n_err++; $display("FAIL reset_noen got=%0d exp=0", bus.Qnext_0); end
   endtask

   task automatic test_trap();
      do_write(2'd1, 5'd6, 5'd17, 4'd2);
      bus.next_state = 5'd6;
      #1;
      n_chk++; if (bus.Qnext_1 !== -32'sd25) begin n_err++; $display("FAIL trap_qn1 got=%0d exp=-25", bus.Qnext_1); end
      n_chk++; if (bus.Q_max !== 32'sd0) begin n_err++; $display("FAIL trap_qmax got=%0d exp=0", bus.Q_max); end
      n_chk++; if (bus.Qnext_0 !== 32'sd0) begin n_err++; $display("FAIL trap_qn0 got=%0d exp=0", bus.Qnext_0); end
   endtask

   task automatic test_goal();
      do_write(2'd2, 5'd11, 5'd25, 4'd3);
      bus.next_state = 5'd11;
      #1;
      n_chk++; if (bus.Qnext_2 !== 32'sd50) begin n_err++; $display("FAIL goal_qn2 got=%0d exp=50", bus.Qnext_2); end
      n_chk++; if (bus.Q_max !== 32'sd50) begin n_err++; $display("FAIL goal_qmax got=%0d exp=50", bus.Q_max); end
   endtask

   task automatic test_arith();
      // Q_sa=-25, Q_max=0, r=100 -> 37
      do_write(2'd1, 5'd6, 5'd25, 4'd3);
      bus.next_state = 5'd6;
      #1;
      n_chk++; if (bus.Qnext_1 !== 32'sd37) begin n_err++; $display("FAIL arith_37 got=%0d exp=37", bus.Qnext_1); end
      n_chk++; if (bus.Q_max !== 32'sd37) begin n_err++; $display("FAIL arith_37_max got=%0d exp=37", bus.Q_max); end
      // trap twice: 0 -> -25 -> -38 (floor of -25/2)
      do_write(2'd0, 5'd3, 5'd8, 4'd2);
      bus.next_state = 5'd3;
      #1;
      n_chk++; if (bus.Qnext_0 !== -32'sd25) begin n_err++; $display("FAIL arith_m25 got=%0d exp=-25", bus.Qnext_0); end
      do_write(2'd0, 5'd3, 5'd8, 4'd2);
      bus.next_state = 5'd3;
      #1;
      n_chk++; if (bus.Qnext_0 !== -32'sd38) begin n_err++; $display("FAIL arith_m38 got=%0d exp=-38", bus.Qnext_0); end
      for (int k = 0; k < 4; k++) begin
         do_write(2'(k), 5'd20, 5'd19, 4'd4);
      end
      bus.next_state = 5'd20;
      #1;
      n_chk++; if (bus.Q_max !== -32'sd25) begin n_err++; $display("FAIL arith_negmax got=%0d exp=-25", bus.Q_max); end
      n_chk++; if (bus.Qnext_3 !== -32'sd25) begin n_err++; $display("FAIL arith_qn3_20 got=%0d exp=-25", bus.Qnext_3); end
      // Q_sa=0, Q_max=-25, r=0 -> -7
      do_write(2'd3, 5'd2, 5'd20, 4'd4);
      bus.next_state = 5'd2;
      #1;
      n_chk++; if (bus.Qnext_3 !== -32'sd7) begin n_err++; $display("FAIL arith_m7 got=%0d exp=-7", bus.Qnext_3); end
      n_chk++; if (bus.Q_max !== 32'sd0) begin n_err++; $display("FAIL arith_m7_max got=%0d exp=0", bus.Q_max); end
   endtask

   task automatic test_hold();
      drive(1'b0, 2'd1, 5'd6, 5'd6, 4'd5);
      tick();
      n_chk++; if (bus.Qnext_1 !== 32'sd37) begin n_err++; $display("FAIL hold_qn1 got=%0d exp=37", bus.Qnext_1); end
   endtask

   task automatic test_rdw();
      drive(1'b1, 2'd1, 5'd6, 5'd6, 4'd5);
      #1;
      n_chk++; if (bus.Qnext_1 !== 32'sd37) begin n_err++; $display("FAIL rdw_old got=%0d exp=37", bus.Qnext_1); end
      tick();
      bus.decoder_en = 1'b0;
      #1;
      // 37 + ((0 + 18 - 37) >>> 1) = 27
      n_chk++; if (bus.Qnext_1 !== 32'sd27) begin n_err++; $display("FAIL rdw_new got=%0d exp=27", bus.Qnext_1); end
   endtask

   task automatic test_step_reward();
      do_write(2'd0, 5'd4, 5'd1, 4'd15);
      bus.next_state = 5'd4;
      #1;
      n_chk++; if (bus.Qnext_0 !== -32'sd25) begin n_err++; $display("FAIL timeout got=%0d exp=-25", bus.Qnext_0); end
      do_write(2'd0, 5'd7, 5'd25, 4'd15);
      bus.next_state = 5'd7;
      #1;
      n_chk++; if (bus.Qnext_0 !== 32'sd50) begin n_err++; $display("FAIL goal_over_timeout got=%0d exp=50", bus.Qnext_0); end
      do_write(2'd0, 5'd5, 5'd2, 4'd4);
      bus.next_state = 5'd5;
      #1;
      n_chk++; if (bus.Qnext_0 !== 32'sd0) begin n_err++; $display("FAIL ordinary got=%0d exp=0", bus.Qnext_0); end
   endtask

   task automatic test_oob();
      do_write(2'd3, 5'd0, 5'd25, 4'd1);
      do_write(2'd0, 5'd31, 5'd12, 4'd1);
      bus.next_state = 5'd0;
      #1;
      n_chk++; if (bus.Qnext_3 !== 32'sd50) begin n_err++; $display("FAIL oob_addr0 got=%0d exp=50", bus.Qnext_3); end
      bus.next_state = 5'd31;
      #1;
      n_chk++; if (bus.Qnext_0 !== -32'sd25) begin n_err++; $display("FAIL oob_addr31 got=%0d exp=-25", bus.Qnext_0); end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 2'd1, 5'd6, 5'd6, 4'd5);
      #1;
      n_chk++; if (bus.Qnext_1 !== 32'sd27) begin n_err++; $display("FAIL ar_pre got=%0d exp=27", bus.Qnext_1); end
      rst = 1'b1;
      #1;
      n_chk++; if (bus.Qnext_1 !== 32'sd0) begin n_err++; $display("FAIL ar_qn1 got=%0d exp=0", bus.Qnext_1); end
      n_chk++; if (bus.Q_max !== 32'sd0) begin n_err++; $display("FAIL ar_qmax got=%0d exp=0", bus.Q_max); end
      tick();
      rst = 1'b0;
      bus.decoder_en = 1'b0;
      #1;
      n_chk++; if (bus.Qnext_1 !== 32'sd0) begin n_err++; $display("FAIL ar_blocked got=%0d exp=0", bus.Qnext_1); end
      bus.next_state = 5'd11;
      #1;
      n_chk++; if (bus.Qnext_2 !== 32'sd0) begin n_err++; $display("FAIL ar_qn2 got=%0d exp=0", bus.Qnext_2); end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b0;
      drive(1'b0, 2'd0, 5'd0, 5'd0, 4'd0);
      test_reset();
      test_trap();
      test_goal();
      test_arith();
      test_hold();
      test_rdw();
      test_step_reward();
      test_oob();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
